// File: rtl/aes_job_arbiter_pkg.sv
// Shared AES definitions: block/key widths, default round-run length and
// the job arbiter state encoding.
package aes_job_arbiter_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int AES_KEY_W      = 128;
  localparam int RUN_CYCLES_DEF = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_job_arbiter_rr.sv
// Round-robin request picker: scans from ptr upward (wrapping) and returns
// the first active request as a one-hot grant plus its index.
module aes_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_vld
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr is always < NREQ, so one subtraction is enough to wrap
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES core among NREQ requesters: round-robin job grant, operand
// hold while the core runs RUN_CYCLES rounds, then a held response per owner.
module aes_job_arbiter
  import aes_job_arbiter_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int RUN_CYCLES = RUN_CYCLES_DEF,
  localparam int IW         = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*AES_KEY_W-1:0]   req_key,
  input  logic [NREQ*AES_BLOCK_W-1:0] req_ptext,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [AES_BLOCK_W-1:0]      rsp_ctext,
  output logic                        core_start,
  input  logic                        core_accept,
  input  logic                        core_done,
  output logic [AES_KEY_W-1:0]        core_key,
  output logic [AES_BLOCK_W-1:0]      core_ptext,
  input  logic [AES_BLOCK_W-1:0]      core_ctext,
  output logic                        busy,
  output logic [IW-1:0]               owner,
  output logic                        err,
  output aes_state_e                  dbg_state
);

  localparam logic [3:0] CNT_LAST = 4'(RUN_CYCLES - 1);

  // Handshakes: req_ready[i] and req_valid[i] both high at a rising edge
  // transfers a job; rsp_valid[i] and rsp_ready[i] both high retires it.
  // req_ready is only raised in IDLE; rsp_valid only in RESP, never both.

  aes_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [AES_KEY_W-1:0]   key_q, key_d;
  logic [AES_BLOCK_W-1:0] ptext_q, ptext_d;
  logic [AES_BLOCK_W-1:0] result_q, result_d;
  logic                   err_q, err_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_vld;

  aes_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      key_q    <= '0;
      ptext_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      key_q    <= key_d;
      ptext_q  <= ptext_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    key_d      = key_q;
    ptext_d    = ptext_q;
    result_d   = result_q;
    err_d      = err_q;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;

    // A completion pulse is only legitimate while a job is waiting for it
    if (core_done && (state_q != ST_WAIT_DONE)) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          req_ready = grant;
          owner_d   = grant_idx;
          ptr_d     = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
          for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              key_d   = req_key[i*AES_KEY_W +: AES_KEY_W];
              ptext_d = req_ptext[i*AES_BLOCK_W +: AES_BLOCK_W];
            end
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (core_accept) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        core_start = 1'b1;
        if ((cnt_q == '0) && !core_accept) err_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          result_d = core_ctext;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_ctext  = result_q;
  assign core_key   = key_q;
  assign core_ptext = ptext_q;
  assign busy       = (state_q != ST_IDLE);
  assign owner      = owner_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter with a behavioural AES core stand-in
// that counts core_start rounds and returns a table/derived ciphertext.
module tb_aes_job_arbiter;
  import aes_job_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                clk;
  logic                rstn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_key;
  logic [NREQ*128-1:0] req_ptext;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [127:0]        rsp_ctext;
  logic                core_start;
  logic                core_accept;
  logic                core_done;
  logic [127:0]        core_key;
  logic [127:0]        core_ptext;
  logic [127:0]        core_ctext;
  logic                busy;
  logic [1:0]          owner;
  logic                err;
  aes_state_e          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic [127:0] key_tab [NREQ];
  logic [127:0] pt_tab  [NREQ];

  aes_job_arbiter #(.NREQ(NREQ), .RUN_CYCLES(11)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_key     (req_key),
    .req_ptext   (req_ptext),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_ctext   (rsp_ctext),
    .core_start  (core_start),
    .core_accept (core_accept),
    .core_done   (core_done),
    .core_key    (core_key),
    .core_ptext  (core_ptext),
    .core_ctext  (core_ctext),
    .busy        (busy),
    .owner       (owner),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core stand-in: known FIPS-197 vector, otherwise a fixed scramble
  function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_0f0f_f0f0_f0f0;
  endfunction

  logic [3:0]   core_r;
  logic         core_done_q;
  logic [127:0] core_ct_q;
  logic         force_done;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_r      <= '0;
      core_done_q <= 1'b0;
      core_ct_q   <= '0;
    end else begin
      core_done_q <= 1'b0;
      if (core_start) begin
        if (core_r == 4'd10) begin
          core_r      <= '0;
          core_done_q <= 1'b1;
          core_ct_q   <= model_ct(core_key, core_ptext);
        end else begin
          core_r <= core_r + 4'd1;
        end
      end
    end
  end

  assign core_accept = (core_r == 4'd0);
  assign core_done   = core_done_q | force_done;
  assign core_ctext  = core_ct_q;

  always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: expects to be called at negedge+1 with requests already driven
  task automatic serve(input int idx);
    int n;
    int s0;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check_eq("grant", 128'(req_ready), 128'(1) << idx);
    s0 = start_cnt;
    n  = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (rsp_valid == '0 && n < 40);
    check_eq("latency", 128'(n), 128'd14);
    check_eq("rsp_valid", 128'(rsp_valid), 128'(1) << idx);
    check_eq("rsp_ctext", rsp_ctext, model_ct(key_tab[idx], pt_tab[idx]));
    check_eq("owner", 128'(owner), 128'(idx));
    check_eq("run_cycles", 128'(start_cnt - s0), 128'd11);
    rsp_ready[idx] = 1'b1;
    req_valid[idx] = 1'b0;
    @(negedge clk); #1;
    rsp_ready = '0;
    check_eq("rsp_retired", 128'(rsp_valid), 128'd0);
  endtask

  initial begin
    int n;
    int k;
    int s0;
    bit seen;
    key_tab[0] = FIPS_KEY;                                pt_tab[0] = FIPS_PT;
    key_tab[1] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c; pt_tab[1] = 128'h3243f6a8_885a308d_313198a2_e0370734;
    key_tab[2] = 128'hdeadbeef_00000001_cafef00d_12345678; pt_tab[2] = 128'h0badc0de_11111111_22222222_33333333;
    key_tab[3] = 128'hffffffff_eeeeeeee_dddddddd_cccccccc; pt_tab[3] = 128'h01234567_89abcdef_fedcba98_76543210;
    for (int i = 0; i < NREQ; i++) begin
      req_key[i*128 +: 128]   = key_tab[i];
      req_ptext[i*128 +: 128] = pt_tab[i];
    end
    rstn       = 1'b0;
    req_valid  = '0;
    rsp_ready  = '0;
    force_done = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_ready", 128'(req_ready), 128'd0);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_core_start", 128'(core_start), 128'd0);
    check_eq("rst_owner", 128'(owner), 128'd0);
    check_eq("rst_err", 128'(err), 128'd0);
    check_eq("rst_ctext", rsp_ctext, 128'd0);
    check_eq("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    rstn = 1'b1;

    // all four requesting from reset: order 0,1,2,3
    @(negedge clk); req_valid = 4'b1111; #1;
    for (int i = 0; i < NREQ; i++) serve(i);

    // last grant 2, then 1001: 3 before 0
    @(negedge clk); req_valid = 4'b0100; #1;
    serve(2);
    @(negedge clk); req_valid = 4'b1001; #1;
    serve(3);
    serve(0);

    // single FIPS job on requester 0, valid dropped right after grant
    @(negedge clk); req_valid = 4'b0001; #1;
    check_eq("fips_grant", 128'(req_ready), 128'd1);
    s0 = start_cnt;
    @(negedge clk); req_valid = '0; #1;
    n = 1;
    check_eq("fips_busy", 128'(busy), 128'd1);
    check_eq("fips_core_key", core_key, FIPS_KEY);
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check_eq("fips_latency", 128'(n), 128'd14);
    check_eq("fips_rsp_valid", 128'(rsp_valid), 128'd1);
    check_eq("fips_ctext", rsp_ctext, FIPS_CT);
    check_eq("fips_core_pt_hold", core_ptext, FIPS_PT);
    check_eq("fips_run_cycles", 128'(start_cnt - s0), 128'd11);
    rsp_ready = 4'b0001;
    @(negedge clk); #1;
    rsp_ready = '0;
    check_eq("fips_retired", 128'(rsp_valid), 128'd0);

    // backpressure: response held 5 cycles, requester 2 waits
    @(negedge clk); req_valid = 4'b0110; #1;
    check_eq("bp_grant", 128'(req_ready), 128'd2);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (rsp_valid == '0 && n < 40);
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_rsp_valid", 128'(rsp_valid), 128'd2);
      check_eq("bp_ctext", rsp_ctext, model_ct(key_tab[1], pt_tab[1]));
      check_eq("bp_no_grant", 128'(req_ready), 128'd0);
      @(negedge clk); #1;
    end
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk); #1;
    rsp_ready = '0;
    serve(2);

    // reset during the 6th RUN cycle
    @(negedge clk); req_valid = 4'b1000; #1;
    check_eq("mid_grant", 128'(req_ready), 128'd8);
    @(negedge clk); req_valid = '0;
    n = 0; k = 0;
    while (k < 6 && n < 40) begin
      @(negedge clk); #1; n++;
      if (core_start) k++;
    end
    check_eq("mid_run_reached", 128'(k), 128'd6);
    rstn = 1'b0; #1;
    check_eq("mid_core_start", 128'(core_start), 128'd0);
    check_eq("mid_busy", 128'(busy), 128'd0);
    check_eq("mid_rsp_valid", 128'(rsp_valid), 128'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (rsp_valid != '0) seen = 1'b1;
    end
    check_eq("mid_no_rsp", 128'(seen), 128'd0);
    req_valid = 4'b1000; #1;
    serve(3);
    check_eq("err_clean", 128'(err), 128'd0);

    // stray core_done in IDLE sets sticky err
    @(negedge clk); force_done = 1'b1;
    @(negedge clk); force_done = 1'b0; #1;
    check_eq("err_set", 128'(err), 128'd1);
    repeat (5) @(negedge clk);
    #1;
    check_eq("err_sticky", 128'(err), 128'd1);
    check_eq("err_idle", 128'(busy), 128'd0);
    rstn = 1'b0; #1;
    check_eq("err_reset", 128'(err), 128'd0);
    @(negedge clk); rstn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
